// File: rtl/a_event_issuer_pkg.sv
// Shared types and constants for the domain-A event issuer.
// Optional statistics outputs are enabled with A_EVENT_ISSUER_STATS_EN.
package a_event_issuer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    HOLD     = 2'd2,
    WAIT_ACK = 2'd3
  } issuer_state_t;

  localparam int STATS_W = 16;

  localparam int CNT_W_MIN   = 2;
  localparam int CNT_W_MAX   = 16;
  localparam int HOLDOFF_MIN = 1;
  localparam int HOLDOFF_MAX = 15;

  // Wide enough for HOLDOFF_MAX-1.
  localparam int HOLD_W = 4;

  function automatic bit in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/sat_up_down_counter.sv
// Saturating up/down counter: simultaneous inc and dec cancel, inc holds at
// all-ones, dec holds at zero. Clear is synchronous and has priority.
module sat_up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_value,
  output logic             o_saturated
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_value <= '0;
    end else if (i_inc && !i_dec) begin
      if (r_value != MAX_VAL) begin
        r_value <= r_value + 1'b1;
      end
    end else if (i_dec && !i_inc) begin
      if (r_value != '0) begin
        r_value <= r_value - 1'b1;
      end
    end
  end

  assign o_value     = r_value;
  assign o_saturated = (r_value == MAX_VAL);

endmodule

// File: rtl/a_event_issuer.sv
// Domain-A event issuer: counts event pulses as credits and issues them one at
// a time on the vld/rdy handshake. Stats outputs need A_EVENT_ISSUER_STATS_EN.
module a_event_issuer
  import a_event_issuer_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int HOLDOFF = 2
) (
  input  logic             clk_a,
  input  logic             reset_in,
  input  logic             vld_in,
  output logic             vld_out,
  input  logic             rdy_in,
  output logic [CNT_W-1:0] pending_count,
  output logic             overflow_out,
  output logic             busy_out
`ifdef A_EVENT_ISSUER_STATS_EN
  ,
  output logic [STATS_W-1:0] issued_cnt_out,
  output logic [STATS_W-1:0] dropped_cnt_out
`endif
);

  generate
    if (!in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt_w
      $error("a_event_issuer: CNT_W out of range");
    end
    if (!in_range(HOLDOFF, HOLDOFF_MIN, HOLDOFF_MAX)) begin : g_bad_holdoff
      $error("a_event_issuer: HOLDOFF out of range");
    end
  endgenerate

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);

  issuer_state_t     r_state;
  issuer_state_t     w_state_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_next;
  logic              r_vld_out;
  logic              r_overflow;

  logic              w_inc;
  logic              w_handshake;
  logic              w_drop;
  logic              w_cnt_sat;
  logic [CNT_W-1:0]  w_count;

  // Events seen while reset is asserted are discarded.
  assign w_inc       = vld_in & ~reset_in;
  assign w_handshake = (r_state == SEND) & rdy_in;
  // A drop only happens when nothing leaves in the same cycle.
  assign w_drop      = w_inc & ~w_handshake & w_cnt_sat;

  sat_up_down_counter #(
    .WIDTH (CNT_W)
  ) u_pending_cnt (
    .clk         (clk_a),
    .i_clr       (reset_in),
    .i_inc       (w_inc),
    .i_dec       (w_handshake),
    .o_value     (w_count),
    .o_saturated (w_cnt_sat)
  );

  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (w_count != '0) begin
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (rdy_in) begin
          w_state_next    = HOLD;
          w_hold_cnt_next = HOLD_LOAD;
        end
      end
      HOLD: begin
        // rdy_in may still show the previous idle level; wait it out.
        if (r_hold_cnt == '0) begin
          w_state_next = WAIT_ACK;
        end else begin
          w_hold_cnt_next = r_hold_cnt - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (rdy_in) begin
          w_state_next = (w_count != '0) ? SEND : IDLE;
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (reset_in) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_vld_out  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_vld_out  <= (w_state_next == SEND);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign vld_out       = r_vld_out;
  assign pending_count = w_count;
  assign overflow_out  = r_overflow;
  assign busy_out      = (r_state != IDLE);

`ifdef A_EVENT_ISSUER_STATS_EN
  logic w_issued_sat;
  logic w_dropped_sat;
  logic w_stats_unused;

  sat_up_down_counter #(
    .WIDTH (STATS_W)
  ) u_issued_cnt (
    .clk         (clk_a),
    .i_clr       (reset_in),
    .i_inc       (w_handshake),
    .i_dec       (1'b0),
    .o_value     (issued_cnt_out),
    .o_saturated (w_issued_sat)
  );

  sat_up_down_counter #(
    .WIDTH (STATS_W)
  ) u_dropped_cnt (
    .clk         (clk_a),
    .i_clr       (reset_in),
    .i_inc       (w_drop),
    .i_dec       (1'b0),
    .o_value     (dropped_cnt_out),
    .o_saturated (w_dropped_sat)
  );

  // Saturation of the statistics counters is not reported anywhere.
  assign w_stats_unused = w_issued_sat | w_dropped_sat;
`endif

endmodule
